// File: rtl/alu_ops_pkg.sv
// Shared ALU operation codes, RV32I opcodes and the decoded-bundle payload
// exchanged between the decode stage and the execute-stage ALU.
package alu_ops_pkg;

  localparam int unsigned DATA_WIDTH    = 32;
  localparam int unsigned OPCODE_LENGTH = 4;
  localparam int unsigned REG_IDX_W     = 5;

  localparam logic [OPCODE_LENGTH-1:0] ALU_AND = 4'b0000;
  localparam logic [OPCODE_LENGTH-1:0] ALU_XOR = 4'b0001;
  localparam logic [OPCODE_LENGTH-1:0] ALU_SUB = 4'b0010;
  localparam logic [OPCODE_LENGTH-1:0] ALU_OR  = 4'b0011;
  localparam logic [OPCODE_LENGTH-1:0] ALU_ADD = 4'b0100;
  localparam logic [OPCODE_LENGTH-1:0] ALU_BGE = 4'b0101;
  localparam logic [OPCODE_LENGTH-1:0] ALU_BNE = 4'b0110;
  localparam logic [OPCODE_LENGTH-1:0] ALU_SRA = 4'b0111;
  localparam logic [OPCODE_LENGTH-1:0] ALU_EQ  = 4'b1000;
  localparam logic [OPCODE_LENGTH-1:0] ALU_SLL = 4'b1001;
  localparam logic [OPCODE_LENGTH-1:0] ALU_LUI = 4'b1010;
  localparam logic [OPCODE_LENGTH-1:0] ALU_SRL = 4'b1100;
  localparam logic [OPCODE_LENGTH-1:0] ALU_BLT = 4'b1101;
  localparam logic [OPCODE_LENGTH-1:0] ALU_SLT = 4'b1110;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [OPCODE_LENGTH-1:0] operation;
    logic                     alu_src_imm;
    logic [DATA_WIDTH-1:0]    imm;
    logic [REG_IDX_W-1:0]     rs1;
    logic [REG_IDX_W-1:0]     rs2;
    logic [REG_IDX_W-1:0]     rd;
    logic                     reg_write;
    logic                     is_branch;
    logic                     illegal;
  } alu_decoded_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I instruction decoder producing the ALU bundle.
module alu_op_decode
  import alu_ops_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] instr,
  output alu_decoded_t          dec_c
);

  logic [6:0]            opcode;
  logic [2:0]            f3;
  logic [6:0]            f7;
  logic [DATA_WIDTH-1:0] i_imm, s_imm, b_imm, u_imm, j_imm, shamt;
  logic                  bad;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign i_imm  = {{20{instr[31]}}, instr[31:20]};
  assign s_imm  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign b_imm  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign u_imm  = {instr[31:12], 12'b0};
  assign j_imm  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign shamt  = DATA_WIDTH'(instr[24:20]);

  always_comb begin
    dec_c = '0;
    bad   = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_c.rs1       = instr[19:15];
        dec_c.rs2       = instr[24:20];
        dec_c.rd        = instr[11:7];
        dec_c.reg_write = 1'b1;
        case (f3)
          3'b000: begin
            if (f7 == F7_ZERO)     dec_c.operation = ALU_ADD;
            else if (f7 == F7_ALT) dec_c.operation = ALU_SUB;
            else                   bad = 1'b1;
          end
          3'b111:  dec_c.operation = ALU_AND;
          3'b110:  dec_c.operation = ALU_OR;
          3'b100:  dec_c.operation = ALU_XOR;
          3'b010:  dec_c.operation = ALU_SLT;
          3'b001:  dec_c.operation = ALU_SLL;
          3'b101:  dec_c.operation = ALU_SRL;
          default: bad = 1'b1;
        endcase
        // Only ADD/SUB may carry a non-zero funct7; this also rejects register SRA.
        if (f3 != 3'b000 && f7 != F7_ZERO) bad = 1'b1;
      end
      OPC_OP_IMM: begin
        dec_c.rs1         = instr[19:15];
        dec_c.rd          = instr[11:7];
        dec_c.reg_write   = 1'b1;
        dec_c.alu_src_imm = 1'b1;
        dec_c.imm         = i_imm;
        case (f3)
          3'b000: dec_c.operation = ALU_ADD;
          3'b111: dec_c.operation = ALU_AND;
          3'b110: dec_c.operation = ALU_OR;
          3'b100: dec_c.operation = ALU_XOR;
          3'b010: dec_c.operation = ALU_SLT;
          3'b001: begin
            dec_c.operation = ALU_SLL;
            dec_c.imm       = shamt;
            if (f7 != F7_ZERO) bad = 1'b1;
          end
          3'b101: begin
            // SRAI keeps the raw I-immediate; the ALU strips the funct7 bias.
            if (f7 == F7_ZERO) begin
              dec_c.operation = ALU_SRL;
              dec_c.imm       = shamt;
            end else if (f7 == F7_ALT) begin
              dec_c.operation = ALU_SRA;
            end else begin
              bad = 1'b1;
            end
          end
          default: bad = 1'b1;
        endcase
      end
      OPC_LUI: begin
        dec_c.operation   = ALU_LUI;
        dec_c.rd          = instr[11:7];
        dec_c.reg_write   = 1'b1;
        dec_c.alu_src_imm = 1'b1;
        dec_c.imm         = u_imm;
      end
      OPC_LOAD: begin
        dec_c.operation   = ALU_ADD;
        dec_c.rs1         = instr[19:15];
        dec_c.rd          = instr[11:7];
        dec_c.reg_write   = 1'b1;
        dec_c.alu_src_imm = 1'b1;
        dec_c.imm         = i_imm;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) bad = 1'b1;
      end
      OPC_STORE: begin
        dec_c.operation   = ALU_ADD;
        dec_c.rs1         = instr[19:15];
        dec_c.rs2         = instr[24:20];
        dec_c.alu_src_imm = 1'b1;
        dec_c.imm         = s_imm;
        if (f3 > 3'b010) bad = 1'b1;
      end
      OPC_JAL: begin
        dec_c.operation   = ALU_ADD;
        dec_c.rd          = instr[11:7];
        dec_c.reg_write   = 1'b1;
        dec_c.alu_src_imm = 1'b1;
        dec_c.imm         = j_imm;
      end
      OPC_JALR: begin
        dec_c.operation   = ALU_ADD;
        dec_c.rs1         = instr[19:15];
        dec_c.rd          = instr[11:7];
        dec_c.reg_write   = 1'b1;
        dec_c.alu_src_imm = 1'b1;
        dec_c.imm         = i_imm;
        if (f3 != 3'b000) bad = 1'b1;
      end
      OPC_BRANCH: begin
        dec_c.rs1       = instr[19:15];
        dec_c.rs2       = instr[24:20];
        dec_c.is_branch = 1'b1;
        dec_c.imm       = b_imm;
        case (f3)
          3'b000:  dec_c.operation = ALU_EQ;
          3'b001:  dec_c.operation = ALU_BNE;
          3'b100:  dec_c.operation = ALU_BLT;
          3'b101:  dec_c.operation = ALU_BGE;
          default: bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase
    // Illegal encodings emit an all-zero bundle with only the flag set.
    if (bad) begin
      dec_c         = '0;
      dec_c.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered decode stage: decodes on the input side and buffers bundles in a
// two-entry skid buffer (main M drives outputs, skid S absorbs one stall).
module alu_decode_stage
  import alu_ops_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    instr,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     alu_src_imm,
  output logic [DATA_WIDTH-1:0]    imm,
  output logic [REG_IDX_W-1:0]     rs1,
  output logic [REG_IDX_W-1:0]     rs2,
  output logic [REG_IDX_W-1:0]     rd,
  output logic                     reg_write,
  output logic                     is_branch,
  output logic                     illegal
);

  alu_decoded_t dec_c;
  alu_decoded_t m_q, m_d, s_q, s_d;
  logic         m_valid_q, m_valid_d, s_valid_q, s_valid_d;
  logic         in_ready_q;
  logic         accept, emit;

  alu_op_decode u_dec (
    .instr (instr),
    .dec_c (dec_c)
  );

  assign accept = in_valid && in_ready_q;
  assign emit   = m_valid_q && out_ready;

  // Next-state for the skid buffer; flush overrides any accept or emit.
  always_comb begin
    m_d       = m_q;
    s_d       = s_q;
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else begin
      if (emit) begin
        if (s_valid_q) begin
          m_d       = s_q;
          s_valid_d = 1'b0;
        end else begin
          m_valid_d = 1'b0;
        end
      end
      // Accept implies S is empty, so only M or S (never both) is loaded.
      if (accept) begin
        if (!m_valid_q || emit) begin
          m_d       = dec_c;
          m_valid_d = 1'b1;
        end else begin
          s_d       = dec_c;
          s_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q        <= '0;
      s_q        <= '0;
      m_valid_q  <= 1'b0;
      s_valid_q  <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      m_q        <= m_d;
      s_q        <= s_d;
      m_valid_q  <= m_valid_d;
      s_valid_q  <= s_valid_d;
      in_ready_q <= !s_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = m_valid_q;
  assign Operation   = m_q.operation;
  assign alu_src_imm = m_q.alu_src_imm;
  assign imm         = m_q.imm;
  assign rs1         = m_q.rs1;
  assign rs2         = m_q.rs2;
  assign rd          = m_q.rd;
  assign reg_write   = m_q.reg_write;
  assign is_branch   = m_q.is_branch;
  assign illegal     = m_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage: decode vector table plus handshake,
// flush and reset sequences.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] instr, imm;
  logic [3:0]  Operation;
  logic        alu_src_imm, reg_write, is_branch, illegal;
  logic [4:0]  rs1, rs2, rd;

  int n_tests = 0;
  int n_fail  = 0;

  alu_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .Operation(Operation), .alu_src_imm(alu_src_imm), .imm(imm),
    .rs1(rs1), .rs2(rs2), .rd(rd), .reg_write(reg_write),
    .is_branch(is_branch), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  op;
    logic        src;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, br, ill;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [31:0] i, input logic [3:0] op, input logic src,
                              input logic [31:0] im, input logic [4:0] a, input logic [4:0] b,
                              input logic [4:0] d, input logic rw, input logic br, input logic il);
    vec_t v;
    v.instr = i; v.op = op; v.src = src; v.imm = im;
    v.rs1 = a; v.rs2 = b; v.rd = d; v.rw = rw; v.br = br; v.ill = il;
    return v;
  endfunction

  function automatic logic [63:0] pack(input logic [3:0] op, input logic src, input logic [31:0] im,
                                       input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                                       input logic rw, input logic br, input logic il);
    return 64'({op, src, im, a, b, d, rw, br, il});
  endfunction

  function automatic logic [63:0] actual();
    return pack(Operation, alu_src_imm, imm, rs1, rs2, rd, reg_write, is_branch, illegal);
  endfunction

  function automatic logic [63:0] expected(input vec_t v);
    return pack(v.op, v.src, v.imm, v.rs1, v.rs2, v.rd, v.rw, v.br, v.ill);
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = mk(32'h002081B3, 4'b0100, 1'b0, 32'h0,        5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0); // add
    vecs[1]  = mk(32'h402081B3, 4'b0010, 1'b0, 32'h0,        5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0); // sub
    vecs[2]  = mk(32'h40335293, 4'b0111, 1'b1, 32'h00000403, 5'd6, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0); // srai
    vecs[3]  = mk(32'h00209463, 4'b0110, 1'b0, 32'h00000008, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1, 1'b0); // bne
    vecs[4]  = mk(32'h000080E7, 4'b0100, 1'b1, 32'h0,        5'd1, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0); // jalr
    vecs[5]  = mk(32'h0000000B, 4'b0000, 1'b0, 32'h0,        5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1); // custom
    vecs[6]  = mk(32'h123452B7, 4'b1010, 1'b1, 32'h12345000, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0); // lui
    vecs[7]  = mk(32'hFFF00093, 4'b0100, 1'b1, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0); // addi -1
    vecs[8]  = mk(32'h00509113, 4'b1001, 1'b1, 32'h00000005, 5'd1, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0); // slli
    vecs[9]  = mk(32'h4020D1B3, 4'b0000, 1'b0, 32'h0,        5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1); // sra reg
    vecs[10] = mk(32'h0020F463, 4'b0000, 1'b0, 32'h0,        5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1); // bgeu
    vecs[11] = mk(32'h0020A223, 4'b0100, 1'b1, 32'h00000004, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0); // sw
    vecs[12] = mk(32'hFE20CEE3, 4'b1101, 1'b0, 32'hFFFFFFFC, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1, 1'b0); // blt -4
    vecs[13] = mk(32'h0020F1B3, 4'b0000, 1'b0, 32'h0,        5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0); // and
    vecs[14] = mk(32'h00335293, 4'b1100, 1'b1, 32'h00000003, 5'd6, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0); // srli

    in_valid = 1'b0; instr = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) tick();
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_bundle", actual(), 64'd0);
    rst_n = 1'b1;

    // Back-to-back decode table at full throughput
    for (int i = 0; i < NV; i++) begin
      instr = vecs[i].instr; in_valid = 1'b1;
      tick();
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d_bundle", i), actual(), expected(vecs[i]));
    end
    in_valid = 1'b0;
    tick();
    chk("drain_valid", 64'(out_valid), 64'd0);

    // Stall for three cycles with three offered words
    out_ready = 1'b0; in_valid = 1'b1; instr = vecs[0].instr;
    tick();
    chk("stall1_valid", 64'(out_valid), 64'd1);
    chk("stall1_in_ready", 64'(in_ready), 64'd1);
    instr = vecs[1].instr;
    tick();
    chk("stall2_in_ready", 64'(in_ready), 64'd0);
    chk("stall2_hold", actual(), expected(vecs[0]));
    instr = vecs[2].instr;
    tick();
    chk("stall3_in_ready", 64'(in_ready), 64'd0);
    chk("stall3_hold", actual(), expected(vecs[0]));
    out_ready = 1'b1;
    tick();
    chk("rel1_bundle", actual(), expected(vecs[1]));
    chk("rel1_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("rel2_valid", 64'(out_valid), 64'd1);
    chk("rel2_bundle", actual(), expected(vecs[2]));
    tick();
    chk("rel3_valid", 64'(out_valid), 64'd0);

    // Flush with both entries full and a word offered
    out_ready = 1'b0; in_valid = 1'b1; instr = vecs[0].instr;
    tick();
    instr = vecs[1].instr;
    tick();
    chk("fl_full_in_ready", 64'(in_ready), 64'd0);
    flush = 1'b1; instr = vecs[6].instr;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("fl_quiet%0d", i), 64'(out_valid), 64'd0);
    end
    // Flush while the stage is empty and accepting
    flush = 1'b1; in_valid = 1'b1; instr = vecs[6].instr;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_accept_dropped", 64'(out_valid), 64'd0);
    tick();
    chk("fl_accept_quiet", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-stream
    out_ready = 1'b0; in_valid = 1'b1; instr = vecs[0].instr;
    tick();
    in_valid = 1'b0;
    chk("rst_pre_valid", 64'(out_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 64'(out_valid), 64'd0);
    chk("rst_async_bundle", actual(), 64'd0);
    chk("rst_async_in_ready", 64'(in_ready), 64'd1);
    #1 rst_n = 1'b1;
    in_valid = 1'b1; instr = vecs[2].instr; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("rst_first_accept", 64'(out_valid), 64'd1);
    chk("rst_first_bundle", actual(), expected(vecs[2]));
    tick();
    chk("rst_final_idle", 64'(out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_decode_stage.md
# alu_decode_stage

Registered decode stage that turns a fetched RV32I instruction word into the 4-bit ALU `Operation` code, operand-select, immediate and register fields consumed by the execute-stage ALU. It sits between fetch and execute and decouples them with a valid/ready handshake and a two-entry skid buffer, so execute can stall without fetch losing instructions. It is the producer side of the ALU operation interface; every code it emits uses the ALU's 4-bit encoding.

## Interface
- `DATA_WIDTH`, 32: instruction, immediate and PC width.
- `OPCODE_LENGTH`, 4: width of `Operation`.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  instruction offered by fetch.
- `in_ready`  out  1  stage can accept this cycle.
- `instr`  in  32  instruction word.
- `flush`  in  1  discard all held and incoming instructions.
- `out_valid`  out  1  decoded bundle valid.
- `out_ready`  in  1  execute accepts the bundle.
- `Operation`  out  4  ALU code.
- `alu_src_imm`  out  1  SrcB = `imm` (1) or rs2 data (0).
- `imm`  out  32  sign-extended immediate.
- `rs1`, `rs2`, `rd`  out  5 each  register indices.
- `reg_write`  out  1  instruction writes `rd`.
- `is_branch`  out  1  conditional branch.
- `illegal`  out  1  unsupported encoding; `Operation`=0000, `reg_write`=0.

## Operation
- ALU codes: AND 0000, XOR 0001, SUB 0010, OR 0011, ADD 0100, BGE 0101, BNE 0110, SRA 0111, EQ 1000, SLL 1001, LUI 1010, SRL 1100, BLT 1101, SLT 1110.
- R-type (0110011): ADD/SUB (funct7[5]), AND, OR, XOR, SLT, SLL, SRL. R-type SRA asserts `illegal`.
- I-ALU (0010011): ADDI, ANDI, ORI, XORI, SLTI, SLLI, SRLI, SRAI. SRAI `imm` is the raw I-immediate including funct7, i.e. 1024+shamt; the ALU removes the bias. SLLI/SRLI `imm` = shamt, zero-extended.
- LUI → 1010, `imm` = {instr[31:12], 12'b0}. Loads, stores, JAL, JALR → ADD (0100). JALR never emits 0111.
- Branches (1100011): BEQ → 1000, BNE → 0110, BLT → 1101, BGE → 0101; `is_branch`=1, `alu_src_imm`=0, `reg_write`=0, `imm` = B-immediate. Unsigned branches are `illegal`.
- All other opcodes: `illegal`=1.
- Skid buffer: main register M drives the outputs; skid register S holds one extra bundle. Accept occurs when `in_valid && in_ready`; emit occurs when `out_valid && out_ready`.
  - Accept with M empty, or with M emitting and S empty: load M.
  - Accept with M full, not emitting: load S.
  - Emit with S full: S→M.
- `in_ready` = !S.valid, registered. No combinational path from `out_ready` to `in_ready`.
- Order is preserved and no bundle is duplicated or dropped.

## Timing
- Reset: `out_valid`=0, `in_ready`=1, and all data outputs (`Operation`, `imm`, fields, flags) are 0.
- Latency is one cycle from accept to `out_valid`. Throughput is 1 per cycle while `out_ready`=1.
- `flush`: M and S are both invalid the next cycle, and an accept in the same cycle is discarded. Flush wins over a simultaneous accept or emit. `in_ready`=1 the cycle after a flush.
- Bundle outputs hold stable while `out_valid && !out_ready`.
- Reset asserted mid-stream clears both entries immediately and asynchronously. The first accept is allowed on the first edge after deassertion.

## Structure
- Package `alu_ops_pkg`: 4-bit ALU code localparams, RV32I opcode localparams, packed struct `alu_decoded_t` (Operation, alu_src_imm, imm, rs1, rs2, rd, reg_write, is_branch, illegal).
- Sub-module `alu_op_decode`: purely combinational `instr` → `alu_decoded_t`, instantiated once on the input side. The stage registers the struct in M/S.

## Test plan
- `0x002081B3` (ADD x3,x1,x2) → next cycle `Operation`=0100, `alu_src_imm`=0, rs1=1, rs2=2, rd=3, `reg_write`=1. `0x402081B3` → 0010.
- `0x40335293` (SRAI x5,x6,3) → `Operation`=0111, `imm`=0x00000403, `alu_src_imm`=1, rd=5.
- `0x00209463` (BNE x1,x2,8) → `Operation`=0110, `is_branch`=1, `imm`=8, `reg_write`=0. JALR `0x000080E7` → 0100.
- `out_ready`=0 for 3 cycles with 3 back-to-back valid inputs → two bundles accepted, `in_ready`=0 from the cycle after the second accept. On release, the bundles emerge in order with the third following and none lost.
- `flush` with M and S full and `in_valid`=1 → `out_valid`=0 and `in_ready`=1 next cycle, and the offered word is never emitted. `rst_n` pulsed mid-stream → outputs zero immediately.
- Opcode `0x0000000B` → `illegal`=1, `Operation`=0000, `reg_write`=0.
